fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 16-bit, 5-bit-opcode core. It owns the PC and issues single-outstanding requests to instruction memory. It buffers returned words and presents opcode/op_ext to the control decoder every cycle. It stops fetching once the decoder flags HALT in the IF/ID slot, and supports stall from hazard logic and redirect from branch/jump resolution.

Parameters:
PC_W, 16, PC and instruction-memory address width
RESET_PC, 0, PC value loaded at reset
NOP_INSTR, 16'h0800, word presented when the IF/ID slot is empty (opcode 5'b00001 = NOP)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard stall; IF/ID slot holds its contents
redirect  in  1  branch/jump taken in EX; flush and refetch
redirect_pc  in  PC_W  target PC, valid with redirect
halt  in  1  control decoder halt output for the word in the IF/ID slot
imem_req  out  1  fetch request, one-cycle pulse
imem_addr  out  PC_W  fetch address, valid with imem_req
imem_rdata  in  16  fetched word
imem_valid  in  1  imem_rdata valid; earliest one cycle after imem_req
instr  out  16  IF/ID instruction word
opcode  out  5  instr[15:11], to decoder
op_ext  out  2  instr[1:0], to decoder
pc_plus2  out  PC_W  fetch PC + 2 of the word in the IF/ID slot
instr_valid  out  1  IF/ID slot holds a real instruction
halted  out  1  fetch permanently stopped

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=RUN; outstanding=0; kill=0; buf_valid=0; instr_valid=0; halted=0.
  - imem_req=0; instr=NOP_INSTR; pc_plus2=0.
- States: RUN, HALTED. HALTED is left only by reset.
- Request:
  - imem_req=1 when state=RUN, outstanding=0, buf_valid=0, redirect=0; imem_addr=pc.
  - On issue: outstanding<=1; pc<=pc+2, modulo 2^PC_W (0xFFFE wraps to 0x0000).
  - The fetch PC+2 is tracked with the request.
- Response: imem_valid is honoured only when outstanding=1; otherwise it is ignored. On acceptance, outstanding<=0.
  - kill=1: word discarded; kill<=0.
  - IF/ID slot empty or being consumed (instr_valid=0 or stall=0): word enters the IF/ID slot next cycle.
  - Otherwise: word goes to the one-entry holding buffer (buf_valid<=1).
- IF/ID slot advance (stall=0):
  - Slot loads from buffer (priority) or from the response.
  - With neither available, instr_valid<=0.
  - stall=1 with instr_valid=1: instr, pc_plus2, instr_valid hold.
- Redirect (priority over everything except reset), in the redirect cycle:
  - instr_valid<=0; buf_valid<=0; pc<=redirect_pc; no request issued.
  - If outstanding=1 and imem_valid=0, kill<=1 (the next response is dropped).
  - If state=HALTED, redirect is ignored.
- Halt: halt=1 and instr_valid=1 and stall=0 and redirect=0 → state<=HALTED, halted<=1.
  - From then on, no further requests.
  - Outstanding responses are discarded; buffer is cleared.
  - instr_valid<=0 after the HALT word is consumed.
  - halt with stall=1 is not acted on until stall drops.
- Outputs:
  - opcode and op_ext are combinational slices of instr.
  - instr=NOP_INSTR whenever instr_valid=0.
- Throughput: with 1-cycle memory latency and no stall, one instruction per 2 cycles (single outstanding).
- Reset mid-operation: all state returns to reset values immediately; late imem_valid after reset is ignored because outstanding=0.

Test Plan:
- Reset release, memory latency 1, words at 0x0000 and 0x0002:
  - imem_req at cycle 1, addr 0x0000.
  - instr_valid=1 with instr=word0 and pc_plus2=0x0002 at cycle 3.
  - Next request addr 0x0002.
- stall=1 for 4 cycles while a response returns:
  - IF/ID holds the old word; the new word sits in the buffer; no new imem_req.
  - On stall release, the buffered word appears the next cycle.
- redirect=1 to 0x0040 with a request outstanding:
  - The late response is dropped; instr_valid=0.
  - Next imem_addr=0x0040; the first valid instr is the word at 0x0040.
- HALT word (opcode 00000) in the slot, halt=1, stall=0:
  - halted=1 next cycle; imem_req stays 0 for 20 cycles; a redirect afterwards is ignored.
- PC wrap: redirect to 0xFFFE:
  - Fetches addr 0xFFFE then 0x0000; pc_plus2=0x0000 for the word at 0xFFFE.
- rst_n pulsed low mid-fetch:
  - Outputs at reset values asynchronously.
  - A stray imem_valid in the next cycle is ignored; the first request is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register: owns the PC, keeps one imem request in flight,
// buffers one returned word while ID is stalled, and stops fetching for good on HALT.
module fetch_stage #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [15:0]     NOP_INSTR = 16'h0800
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [15:0]     instr,
    output logic [4:0]      opcode,
    output logic [1:0]      op_ext,
    output logic [PC_W-1:0] pc_plus2,
    output logic            instr_valid,
    output logic            halted
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc2_q, req_pc2_d;
    logic [PC_W-1:0] buf_pc2_q, buf_pc2_d;
    logic [PC_W-1:0] pc_plus2_q, pc_plus2_d;
    logic [15:0]     buf_instr_q, buf_instr_d;
    logic [15:0]     instr_q, instr_d;
    logic            outstanding_q, outstanding_d;
    logic            kill_q, kill_d;
    logic            buf_valid_q, buf_valid_d;
    logic            instr_valid_q, instr_valid_d;

    logic issue;
    logic accept;
    logic resp_live;
    logic slot_load;
    logic halt_take;

    // Request is gated by rst_n so the port reads 0 while reset is held.
    assign issue     = rst_n && (state_q == RUN) && !outstanding_q && !buf_valid_q && !redirect;
    assign accept    = outstanding_q && imem_valid;
    assign resp_live = accept && !kill_q;
    assign slot_load = !stall || !instr_valid_q;
    assign halt_take = (state_q == RUN) && halt && instr_valid_q && !stall && !redirect;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc2_d     = req_pc2_q;
        buf_pc2_d     = buf_pc2_q;
        pc_plus2_d    = pc_plus2_q;
        buf_instr_d   = buf_instr_q;
        instr_d       = instr_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        buf_valid_d   = buf_valid_q;
        instr_valid_d = instr_valid_q;

        if (issue) begin
            outstanding_d = 1'b1;
            pc_d          = pc_q + PC_W'(2);
            req_pc2_d     = pc_q + PC_W'(2);
        end

        if (accept) begin
            outstanding_d = 1'b0;
            kill_d        = 1'b0;
        end

        // Once halted, any late response is swallowed and the slot stays empty.
        if (state_q == HALTED) begin
            buf_valid_d   = 1'b0;
            instr_valid_d = 1'b0;
        end else if (redirect) begin
            instr_valid_d = 1'b0;
            buf_valid_d   = 1'b0;
            pc_d          = redirect_pc;
            if (outstanding_q && !imem_valid) begin
                kill_d = 1'b1;
            end
        end else if (halt_take) begin
            state_d       = HALTED;
            instr_valid_d = 1'b0;
            buf_valid_d   = 1'b0;
        end else if (slot_load) begin
            if (buf_valid_q) begin
                instr_d       = buf_instr_q;
                pc_plus2_d    = buf_pc2_q;
                instr_valid_d = 1'b1;
                buf_valid_d   = 1'b0;
            end else if (resp_live) begin
                instr_d       = imem_rdata;
                pc_plus2_d    = req_pc2_q;
                instr_valid_d = 1'b1;
            end else begin
                instr_valid_d = 1'b0;
            end
        end else if (resp_live) begin
            buf_valid_d = 1'b1;
            buf_instr_d = imem_rdata;
            buf_pc2_d   = req_pc2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            req_pc2_q     <= '0;
            buf_pc2_q     <= '0;
            pc_plus2_q    <= '0;
            buf_instr_q   <= NOP_INSTR;
            instr_q       <= NOP_INSTR;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
            buf_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc2_q     <= req_pc2_d;
            buf_pc2_q     <= buf_pc2_d;
            pc_plus2_q    <= pc_plus2_d;
            buf_instr_q   <= buf_instr_d;
            instr_q       <= instr_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            buf_valid_q   <= buf_valid_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign instr       = instr_valid_q ? instr_q : NOP_INSTR;
    assign opcode      = instr[15:11];
    assign op_ext      = instr[1:0];
    assign pc_plus2    = pc_plus2_q;
    assign instr_valid = instr_valid_q;
    assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model with variable latency, directed scenarios,
// and a randomized run checked against a program-order fetch/consume model.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_valid = 1'b0;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic [1:0]  op_ext;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halted;

    int          vectors = 0;
    int          miscompares = 0;

    // Memory model state: at most one request pending.
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = 16'h0000;
    int          mem_lat = 1;
    logic [15:0] seed_word;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .opcode      (opcode),
        .op_ext      (op_ext),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Odd multiplier keeps words distinct per address, so stale words are detectable.
    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [15:0] m;
        m = a * 16'h9E37;
        return m ^ seed_word;
    endfunction

    // One clock: sample the request, cross the edge, then let the memory answer.
    task automatic tick();
        logic        seen;
        logic [15:0] a;
        @(negedge clk);
        seen = imem_req;
        a    = imem_addr;
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
        if (seen) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_addr = a;
        end
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_valid = 1'b1;
                imem_rdata = word_at(pend_addr);
                pend       = 1'b0;
            end else begin
                pend_cnt = pend_cnt - 1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        stall      = 1'b0;
        redirect   = 1'b0;
        halt       = 1'b0;
        imem_valid = 1'b0;
        pend       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        #1;
        vectors++;
        if ({imem_req, instr_valid, halted} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got req/valid/halted=%b required 000", {imem_req, instr_valid, halted});
        end
        vectors++;
        if ({instr, opcode, op_ext, pc_plus2} !== {NOP, 5'b00001, 2'b00, 16'h0000}) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got instr=%h opcode=%b op_ext=%b pc_plus2=%h required 0800/00001/00/0000",
                     instr, opcode, op_ext, pc_plus2);
        end
    endtask

    task automatic test_first_fetch();
        rst_n   = 1'b1;
        mem_lat = 1;
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL first_req: got req=%b addr=%h required 1/0000", imem_req, imem_addr);
        end
        tick();
        #1;
        vectors++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL first_wait: got req=%b valid=%b required 0/0", imem_req, instr_valid);
        end
        tick();
        #1;
        vectors++;
        if (instr_valid !== 1'b1 || instr !== word_at(16'h0000) || pc_plus2 !== 16'h0002) begin
            miscompares++;
            $display("[TB] FAIL first_instr: got valid=%b instr=%h pc_plus2=%h required 1/%h/0002",
                     instr_valid, instr, pc_plus2, word_at(16'h0000));
        end
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
            miscompares++;
            $display("[TB] FAIL second_req: got req=%b addr=%h required 1/0002", imem_req, imem_addr);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            vectors++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== word_at(16'h0000)) begin
                miscompares++;
                $display("[TB] FAIL stall_hold[%0d]: got req=%b valid=%b instr=%h required 0/1/%h",
                         i, imem_req, instr_valid, instr, word_at(16'h0000));
            end
        end
        tick();
        stall = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b0 || instr !== word_at(16'h0000)) begin
            miscompares++;
            $display("[TB] FAIL stall_release: got req=%b instr=%h required 0/%h", imem_req, instr, word_at(16'h0000));
        end
        tick();
        #1;
        vectors++;
        if (instr_valid !== 1'b1 || instr !== word_at(16'h0002) || pc_plus2 !== 16'h0004) begin
            miscompares++;
            $display("[TB] FAIL stall_buffered: got valid=%b instr=%h pc_plus2=%h required 1/%h/0004",
                     instr_valid, instr, pc_plus2, word_at(16'h0002));
        end
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
            miscompares++;
            $display("[TB] FAIL stall_next_req: got req=%b addr=%h required 1/0004", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect();
        logic found;
        mem_lat = 3;
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL redirect_noreq: got req=%b required 0", imem_req);
        end
        tick();
        redirect = 1'b0;
        mem_lat  = 1;
        found    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req) begin
                found = 1'b1;
                break;
            end
            vectors++;
            if (instr_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL redirect_flush: got valid=%b instr=%h required valid 0", instr_valid, instr);
            end
            tick();
        end
        vectors++;
        if (!found || imem_addr !== 16'h0040) begin
            miscompares++;
            $display("[TB] FAIL redirect_target: got found=%b addr=%h required 1/0040", found, imem_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            if (instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found || instr !== word_at(16'h0040) || pc_plus2 !== 16'h0042) begin
            miscompares++;
            $display("[TB] FAIL redirect_first_instr: got found=%b instr=%h pc_plus2=%h required 1/%h/0042",
                     found, instr, pc_plus2, word_at(16'h0040));
        end
    endtask

    task automatic test_wrap();
        logic [15:0] reqs[$];
        logic [15:0] words[$];
        logic [15:0] pcs[$];
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        mem_lat     = 1;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 20 && words.size() < 2; i++) begin
            #1;
            if (imem_req) reqs.push_back(imem_addr);
            if (instr_valid) begin
                words.push_back(instr);
                pcs.push_back(pc_plus2);
            end
            tick();
        end
        vectors++;
        if (reqs.size() < 2 || words.size() < 2) begin
            miscompares++;
            $display("[TB] FAIL wrap_progress: got %0d reqs %0d instrs required at least 2/2", reqs.size(), words.size());
        end else begin
            vectors++;
            if (reqs[0] !== 16'hFFFE || reqs[1] !== 16'h0000) begin
                miscompares++;
                $display("[TB] FAIL wrap_addr: got %h,%h required FFFE,0000", reqs[0], reqs[1]);
            end
            vectors++;
            if (words[0] !== word_at(16'hFFFE) || pcs[0] !== 16'h0000 ||
                words[1] !== word_at(16'h0000) || pcs[1] !== 16'h0002) begin
                miscompares++;
                $display("[TB] FAIL wrap_instr: got %h@%h,%h@%h required %h@0000,%h@0002",
                         words[0], pcs[0], words[1], pcs[1], word_at(16'hFFFE), word_at(16'h0000));
            end
        end
    endtask

    task automatic test_random_stream();
        logic [15:0] exp_fetch;
        logic [15:0] exp_exec;
        logic [15:0] exp_pc2;
        logic [15:0] exp_word;
        int          consumed;
        int          idle;
        do_reset();
        exp_fetch = 16'h0000;
        exp_exec  = 16'h0000;
        consumed  = 0;
        idle      = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom) & 16'hFFFE;
            mem_lat     = $urandom_range(1, 3);
            #1;
            if (!instr_valid) begin
                vectors++;
                if (instr !== NOP) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_empty_nop cycle %0d: got %h required %h", cyc, instr, NOP);
                end
            end
            if (redirect) begin
                vectors++;
                if (imem_req !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_redirect_req cycle %0d: got req=%b required 0", cyc, imem_req);
                end
                exp_fetch = redirect_pc;
                exp_exec  = redirect_pc;
            end else begin
                if (imem_req) begin
                    vectors++;
                    if (imem_addr !== exp_fetch || pend || imem_valid) begin
                        miscompares++;
                        $display("[TB] FAIL rnd_fetch cycle %0d: got addr=%h busy=%b required addr=%h busy=0",
                                 cyc, imem_addr, pend | imem_valid, exp_fetch);
                    end
                    exp_fetch = exp_fetch + 16'd2;
                end
                if (instr_valid && !stall) begin
                    exp_word = word_at(exp_exec);
                    exp_pc2  = exp_exec + 16'd2;
                    vectors++;
                    if (instr !== exp_word || pc_plus2 !== exp_pc2 ||
                        opcode !== exp_word[15:11] || op_ext !== exp_word[1:0]) begin
                        miscompares++;
                        $display("[TB] FAIL rnd_instr cycle %0d: got %h pc2=%h op=%b ext=%b required %h pc2=%h",
                                 cyc, instr, pc_plus2, opcode, op_ext, exp_word, exp_pc2);
                    end
                    exp_exec = exp_pc2;
                    consumed++;
                    idle = -1;
                end
            end
            idle++;
            if (idle > 40) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL rnd_progress: got no instruction for %0d cycles required at most 40", idle);
                break;
            end
            tick();
        end
        stall    = 1'b0;
        redirect = 1'b0;
        vectors++;
        if (consumed < 60) begin
            miscompares++;
            $display("[TB] FAIL rnd_throughput: got %0d instructions required at least 60", consumed);
        end
    endtask

    task automatic test_reset_midfetch();
        logic [15:0] stray;
        mem_lat = 2;
        tick();
        tick();
        rst_n      = 1'b0;
        pend       = 1'b0;
        imem_valid = 1'b0;
        #1;
        vectors++;
        if ({imem_req, instr_valid, halted} !== 3'b000 || instr !== NOP || pc_plus2 !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got req/valid/halted=%b instr=%h pc2=%h required 000/%h/0000",
                     {imem_req, instr_valid, halted}, instr, pc_plus2, NOP);
        end
        tick();
        stray      = ~word_at(16'h0000);
        rst_n      = 1'b1;
        mem_lat    = 1;
        imem_valid = 1'b1;
        imem_rdata = stray;
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_first_req: got req=%b addr=%h required 1/0000", imem_req, imem_addr);
        end
        tick();
        #1;
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stray_ignored: got valid=%b instr=%h required valid 0", instr_valid, instr);
        end
        tick();
        #1;
        vectors++;
        if (instr_valid !== 1'b1 || instr !== word_at(16'h0000)) begin
            miscompares++;
            $display("[TB] FAIL reset_first_instr: got valid=%b instr=%h required 1/%h", instr_valid, instr, word_at(16'h0000));
        end
    endtask

    task automatic test_halt();
        logic [15:0] held;
        logic        found;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_valid) begin
                found = 1'b1;
                break;
            end
            tick();
            #1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("[TB] FAIL halt_setup: got no valid instruction required one within 10 cycles");
        end
        held  = instr;
        halt  = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            vectors++;
            if (halted !== 1'b0 || instr !== held) begin
                miscompares++;
                $display("[TB] FAIL halt_stalled[%0d]: got halted=%b instr=%h required 0/%h", i, halted, instr, held);
            end
        end
        stall = 1'b0;
        tick();
        halt = 1'b0;
        #1;
        vectors++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || instr !== NOP) begin
            miscompares++;
            $display("[TB] FAIL halt_enter: got halted=%b valid=%b instr=%h required 1/0/%h", halted, instr_valid, instr, NOP);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            vectors++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL halt_quiet[%0d]: got req=%b valid=%b required 0/0", i, imem_req, instr_valid);
            end
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            vectors++;
            if (imem_req !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL halt_redirect_ignored[%0d]: got req=%b halted=%b valid=%b required 0/1/0",
                         i, imem_req, halted, instr_valid);
            end
        end
    endtask

    initial begin
        seed_word = 16'($urandom) ^ 16'h5A3C;
        $display("[TB] fetch_stage bench start");
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect();
        test_wrap();
        test_random_stream();
        test_reset_midfetch();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running required completion within 20000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
